// File: rtl/capture_if.sv
// Capture-control bus: trigger/cmd_cfg side (slave) talking to capture_ctrl (master).
interface capture_if #(
  parameter int LOG2 = 9
);
  logic            run;
  logic            capture_done;
  logic            triggered;
  logic [3:0]      decimator;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] ram_addr;
  logic            set_capture_done;
  logic            armed;
  logic            capturing;

  modport master (
    input  run, capture_done, triggered, decimator, trig_pos,
    output we, waddr, ram_addr, set_capture_done, armed, capturing
  );

  modport slave (
    output run, capture_done, triggered, decimator, trig_pos,
    input  we, waddr, ram_addr, set_capture_done, armed, capturing
  );
endinterface

// File: rtl/capture_ctrl.sv
// Capture sequencer: shared RAMqueue write pointer, decimation, pre-trigger arming,
// post-trigger count and the done handshake with cmd_cfg.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for run with capture_done clear
// S_CAPTURE | filling pre-trigger history; trigger accepted once armed
// S_POST    | writing tp post-trigger samples
// S_DONE    | capture complete; waiting for host to set then clear capture_done
module capture_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic      clk,
  input  logic      rst,
  capture_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_POST, S_DONE} state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   FULL = (LOG2 + 1)'(ENTRIES);

  state_t          state, state_nxt;
  logic [15:0]     dec_cnt;
  logic [15:0]     dec_max;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] ram_addr;
  logic [LOG2-1:0] trig_cnt;
  logic [LOG2-1:0] tp;
  logic [LOG2:0]   smpl_cnt;
  logic [LOG2+1:0] fill_sum;
  logic            set_done;
  logic            done_seen;
  logic            capturing;
  logic            armed;
  logic            en;
  logic            we;
  logic            start;
  logic            go_post;
  logic            finish;

  assign tp        = (bus.trig_pos > LAST) ? LAST : bus.trig_pos;
  assign capturing = (state == S_CAPTURE) || (state == S_POST);
  assign dec_max   = (16'd1 << bus.decimator) - 16'd1;
  assign en        = (dec_cnt == dec_max);
  assign fill_sum  = {1'b0, smpl_cnt} + {2'b00, tp};
  assign armed     = (state == S_CAPTURE) && (fill_sum >= {1'b0, FULL});

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Abort by run=0 takes priority over trigger and completion; the trigger cycle never writes.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    start     = 1'b0;
    go_post   = 1'b0;
    finish    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.run && !bus.capture_done) begin
          state_nxt = S_CAPTURE;
          start     = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (!bus.run) begin
          state_nxt = S_IDLE;
        end else if (bus.triggered && armed) begin
          state_nxt = S_POST;
          go_post   = 1'b1;
        end else begin
          we = en;
        end
      end
      S_POST: begin
        if (!bus.run) begin
          state_nxt = S_IDLE;
        end else if (trig_cnt == tp) begin
          state_nxt = S_DONE;
          finish    = 1'b1;
        end else begin
          we = en;
        end
      end
      S_DONE: begin
        if (done_seen && !bus.capture_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt   <= '0;
      waddr     <= '0;
      ram_addr  <= '0;
      trig_cnt  <= '0;
      smpl_cnt  <= '0;
      set_done  <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      set_done <= finish;

      if (!capturing || en) dec_cnt <= '0;
      else                  dec_cnt <= dec_cnt + 16'd1;

      if (start) begin
        waddr    <= '0;
        smpl_cnt <= '0;
      end else if (we) begin
        waddr <= (waddr == LAST) ? '0 : waddr + 1'b1;
        if (smpl_cnt != FULL) smpl_cnt <= smpl_cnt + 1'b1;
      end

      if (go_post)                     trig_cnt <= '0;
      else if ((state == S_POST) && we) trig_cnt <= trig_cnt + 1'b1;

      // Oldest sample sits where the next write would land.
      if (finish) ram_addr <= waddr;

      if (state == S_DONE) begin
        if (state_nxt == S_IDLE)    done_seen <= 1'b0;
        else if (bus.capture_done)  done_seen <= 1'b1;
      end
    end
  end

  assign bus.we               = we;
  assign bus.waddr            = waddr;
  assign bus.ram_addr         = ram_addr;
  assign bus.set_capture_done = set_done;
  assign bus.armed            = armed;
  assign bus.capturing        = capturing;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed scenarios plus randomized captures
// checked against write-count arithmetic derived from the capture rules.
`timescale 1ns/1ps
module tb_capture_ctrl;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int o_writes, o_pulses, o_ram_addr, o_addr_errs, o_waddr_end;
  bit o_timeout;
  int last_ram_exp = 0;

  capture_if #(.LOG2(LOG2)) bus ();

  capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int tp_of(input int tpos);
    return (tpos > ENTRIES - 1) ? ENTRIES - 1 : tpos;
  endfunction

  function automatic int pre_of(input int tpos, input int tw);
    return (tw > ENTRIES - tp_of(tpos)) ? tw : ENTRIES - tp_of(tpos);
  endfunction

  // Drives one capture from IDLE; triggered rises once tw writes have landed,
  // run drops once abort_at writes have landed (abort_at<0: never).
  task automatic run_capture(input int dec, input int tpos, input int tw, input int abort_at);
    int tail;
    o_writes = 0; o_pulses = 0; o_addr_errs = 0; o_timeout = 1'b0; tail = -1;
    @(negedge clk);
    bus.decimator = dec[3:0];
    bus.trig_pos  = tpos[LOG2-1:0];
    bus.triggered = 1'b0;
    bus.run       = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.triggered = (o_writes >= tw);
      if (abort_at >= 0 && o_writes >= abort_at) begin
        bus.run = 1'b0;
        if (tail < 0) tail = 4;
      end
      #1;
      if (bus.we) begin
        if (bus.waddr !== LOG2'(o_writes % ENTRIES)) o_addr_errs++;
        o_writes++;
      end
      if (bus.set_capture_done) begin
        o_pulses++;
        o_ram_addr = int'(bus.ram_addr);
        if (tail < 0) tail = 4;
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
    if (tail != 0) o_timeout = 1'b1;
    o_waddr_end   = int'(bus.waddr);
    bus.triggered = 1'b0;
  endtask

  task automatic done_handshake();
    @(negedge clk);
    bus.capture_done = 1'b1;
    repeat (2) @(negedge clk);
    bus.capture_done = 1'b0;
    bus.run          = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [LOG2*2+3:0] outs;
    bit pulse_seen;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    outs = {bus.we, bus.waddr, bus.ram_addr, bus.set_capture_done, bus.armed, bus.capturing};
    checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
    if (outs !== '0) errors++;
    rst = 1'b0;
    @(negedge clk);
    bus.decimator = 4'd0; bus.trig_pos = 9'd10; bus.triggered = 1'b0; bus.run = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    outs = {bus.we, bus.waddr, bus.ram_addr, bus.set_capture_done, bus.armed, bus.capturing};
    checks++;
    if (outs !== '0) begin
      $display("FAIL midrun_reset_outputs: got %h want 0", outs);
      errors++;
    end
    pulse_seen = 1'b0;
    bus.run = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.set_capture_done || bus.capturing) pulse_seen = 1'b1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      if (bus.set_capture_done || bus.capturing) pulse_seen = 1'b1;
    end
    checks++;
    if (pulse_seen) begin
      $display("FAIL midrun_reset_quiet: got activity=1 want 0");
      errors++;
    end
  endtask

  task automatic test_pretrigger_fill();
    run_capture(0, 100, 0, -1);
    checks++;
    if (o_timeout) begin $display("FAIL fill_timeout: got 1 want 0"); errors++; end
    checks++;
    if (o_writes != 384) begin $display("FAIL fill_writes: got %0d want 384", o_writes); errors++; end
    checks++;
    if (o_pulses != 1) begin $display("FAIL fill_pulses: got %0d want 1", o_pulses); errors++; end
    checks++;
    if (o_ram_addr != 0) begin $display("FAIL fill_ram_addr: got %0d want 0", o_ram_addr); errors++; end
    checks++;
    if (o_waddr_end != 0) begin $display("FAIL fill_waddr: got %0d want 0", o_waddr_end); errors++; end
    checks++;
    if (o_addr_errs != 0) begin $display("FAIL fill_addr_seq: got %0d bad want 0", o_addr_errs); errors++; end
    last_ram_exp = 0;
    done_handshake();
  endtask

  task automatic test_decimation();
    localparam int NC = 1700;
    int writes, last_w, first_w, gap_errs, addr_errs, armed_errs, armed_first;
    writes = 0; last_w = -1; first_w = -1; gap_errs = 0; addr_errs = 0;
    armed_errs = 0; armed_first = -1;
    @(negedge clk);
    bus.decimator = 4'd2; bus.trig_pos = 9'd50; bus.triggered = 1'b0; bus.run = 1'b1;
    for (int cyc = 0; cyc < NC; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (bus.armed !== (cyc > 0 && writes + 50 >= ENTRIES)) armed_errs++;
      if (bus.armed && armed_first < 0) armed_first = writes;
      if (bus.we) begin
        if (first_w < 0) first_w = cyc;
        if (last_w >= 0 && cyc - last_w != 4) gap_errs++;
        if (bus.waddr !== LOG2'(writes % ENTRIES)) addr_errs++;
        last_w = cyc;
        writes++;
      end
    end
    checks++;
    if (first_w != 4) begin $display("FAIL dec_first_write: got cycle %0d want 4", first_w); errors++; end
    checks++;
    if (gap_errs != 0) begin $display("FAIL dec_spacing: got %0d bad gaps want 0", gap_errs); errors++; end
    checks++;
    if (writes != (NC - 1) / 4) begin $display("FAIL dec_writes: got %0d want %0d", writes, (NC - 1) / 4); errors++; end
    checks++;
    if (addr_errs != 0) begin $display("FAIL dec_wrap_seq: got %0d bad want 0", addr_errs); errors++; end
    checks++;
    if (armed_errs != 0) begin $display("FAIL dec_armed: got %0d bad cycles want 0", armed_errs); errors++; end
    checks++;
    if (armed_first != 334) begin $display("FAIL dec_armed_rise: got %0d want 334", armed_first); errors++; end
    @(negedge clk);
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.we !== 1'b0) begin $display("FAIL dec_abort_we: got %b want 0", bus.we); errors++; end
    @(negedge clk); #1;
    checks++;
    if (bus.capturing !== 1'b0 || bus.set_capture_done !== 1'b0) begin
      $display("FAIL dec_abort_idle: got capturing=%b pulse=%b want 0 0", bus.capturing, bus.set_capture_done);
      errors++;
    end
  endtask

  task automatic test_trig_zero();
    run_capture(0, 0, 500, -1);
    checks++;
    if (o_writes != 500 || o_timeout) begin $display("FAIL tp0_writes: got %0d want 500", o_writes); errors++; end
    checks++;
    if (o_pulses != 1) begin $display("FAIL tp0_pulses: got %0d want 1", o_pulses); errors++; end
    checks++;
    if (o_ram_addr != 116) begin $display("FAIL tp0_ram_addr: got %0d want 116", o_ram_addr); errors++; end
    last_ram_exp = 116;
    done_handshake();
  endtask

  task automatic test_abort();
    int pre;
    pre = pre_of(200, 0);
    run_capture(0, 200, 0, pre + 20);
    checks++;
    if (o_writes != pre + 20) begin $display("FAIL abort_writes: got %0d want %0d", o_writes, pre + 20); errors++; end
    checks++;
    if (o_pulses != 0) begin $display("FAIL abort_pulses: got %0d want 0", o_pulses); errors++; end
    checks++;
    if (int'(bus.ram_addr) != last_ram_exp) begin
      $display("FAIL abort_ram_addr: got %0d want %0d", bus.ram_addr, last_ram_exp); errors++;
    end
    checks++;
    if (bus.capturing !== 1'b0) begin $display("FAIL abort_idle: got %b want 0", bus.capturing); errors++; end
  endtask

  task automatic test_done_handshake();
    bit busy;
    int restart;
    busy = 1'b0;
    @(negedge clk);
    bus.capture_done = 1'b1; bus.run = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.capturing || bus.we) busy = 1'b1;
    end
    checks++;
    if (busy) begin $display("FAIL done_bit_blocks_start: got busy=1 want 0"); errors++; end
    bus.capture_done = 1'b0; bus.run = 1'b0;
    run_capture(1, 30, 0, -1);
    checks++;
    if (o_pulses != 1 || o_ram_addr != 0 || o_writes != 384) begin
      $display("FAIL done_capture: got pulses=%0d ram=%0d writes=%0d want 1 0 384", o_pulses, o_ram_addr, o_writes);
      errors++;
    end
    last_ram_exp = 0;
    busy = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.capturing || bus.we || bus.set_capture_done) busy = 1'b1;
    end
    bus.capture_done = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (bus.capturing || bus.we) busy = 1'b1;
    end
    checks++;
    if (busy) begin $display("FAIL done_holds: got busy=1 want 0"); errors++; end
    bus.capture_done = 1'b0;
    restart = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (bus.we && restart < 0) restart = int'(bus.waddr);
    end
    checks++;
    if (restart != 0) begin $display("FAIL done_restart_waddr: got %0d want 0", restart); errors++; end
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int dec, tpos, tw, total;
    for (int n = 0; n < 6; n++) begin
      dec  = int'($urandom_range(0, 2));
      tpos = int'($urandom_range(0, 511));
      tw   = int'($urandom_range(0, 520));
      total = pre_of(tpos, tw) + tp_of(tpos);
      run_capture(dec, tpos, tw, -1);
      checks++;
      if (o_timeout || o_writes != total || o_pulses != 1) begin
        $display("FAIL rand%0d_counts: got writes=%0d pulses=%0d to=%0d want %0d 1 0 (dec=%0d tp=%0d tw=%0d)",
                 n, o_writes, o_pulses, o_timeout, total, dec, tpos, tw);
        errors++;
      end
      checks++;
      if (o_ram_addr != total % ENTRIES || o_addr_errs != 0) begin
        $display("FAIL rand%0d_addr: got ram=%0d bad=%0d want %0d 0", n, o_ram_addr, o_addr_errs, total % ENTRIES);
        errors++;
      end
      done_handshake();
    end
  endtask

  initial begin
    bus.run = 1'b0; bus.capture_done = 1'b0; bus.triggered = 1'b0;
    bus.decimator = 4'd0; bus.trig_pos = '0;
    test_reset();
    test_pretrigger_fill();
    test_decimation();
    test_trig_zero();
    test_abort();
    test_done_handshake();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
